// File: rtl/sm83_pkg.sv
// Shared types and helpers for the sm83 multi-port register file and its
// shadow-bank dump engine.
package sm83_pkg;

    localparam int DUMP_W = 1;

    typedef enum logic [DUMP_W-1:0] {
        DUMP_IDLE   = 1'b0,
        DUMP_STREAM = 1'b1
    } dump_state_t;

    // A pair write claims both bytes of its aligned pair; a byte write only its own address.
    function automatic logic byte_lane_sel(
        input logic en,
        input logic pair,
        input logic addr_hit,
        input logic pair_hit
    );
        return en & (pair ? pair_hit : addr_hit);
    endfunction

    // Even lane of a pair carries the high half of the write word.
    function automatic logic lane_takes_high(
        input logic pair,
        input logic odd_lane
    );
        return pair & ~odd_lane;
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Valid/ready dump engine: walks the frozen shadow bank one byte per accepted
// beat, holding index and data while the sink stalls.
module regfile_dump_ctrl
    import sm83_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dump_start,
    input  logic                       dump_ready,
    input  logic [NUM_REGS*DATA_W-1:0] shadow_flat,
    output logic                       dump_valid,
    output logic [AW-1:0]              dump_idx,
    output logic [DATA_W-1:0]          dump_data,
    output logic                       dump_last,
    output logic                       dump_busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1'b1);

    dump_state_t         state_r;
    logic [AW-1:0]       idx_r;
    logic [AW-1:0]       idx_next_s;
    logic                valid_r;
    logic                last_r;
    logic                busy_r;
    logic [DATA_W-1:0]   bank_s [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
        assign bank_s[i] = shadow_flat[i*DATA_W +: DATA_W];
    end

    assign idx_next_s = idx_r + ONE_IDX;

    // Dump FSM with index counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DUMP_IDLE;
            idx_r   <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                DUMP_IDLE: begin
                    if (dump_start) begin
                        state_r <= DUMP_STREAM;
                        idx_r   <= '0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        last_r  <= (LAST_IDX == '0);
                    end
                end
                DUMP_STREAM: begin
                    if (dump_ready) begin
                        if (last_r) begin
                            state_r <= DUMP_IDLE;
                            idx_r   <= '0;
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                            last_r  <= 1'b0;
                        end else begin
                            idx_r  <= idx_next_s;
                            last_r <= (idx_next_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_r <= DUMP_IDLE;
                    idx_r   <= '0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow is frozen while streaming, so a plain mux on the held index is stable.
    assign dump_data  = bank_s[idx_r];
    assign dump_valid = valid_r;
    assign dump_idx   = idx_r;
    assign dump_last  = last_r;
    assign dump_busy  = busy_r;

endmodule

// File: rtl/sm83_regfile_mp.sv
// sm83 multi-port byte register file with 16-bit pair access, shadow bank
// (save/restore/exchange) and debug dump. Optional macro: REGFILE_BYPASS_EN.
module sm83_regfile_mp
    import sm83_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0]            wr_pair,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*2*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    input  logic [NUM_RD-1:0]            rd_pair,
    output logic [NUM_RD*2*DATA_W-1:0]   rd_data,
    input  logic                         save_req,
    input  logic                         restore_req,
    input  logic                         dump_start,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [AW-1:0]                dump_idx,
    output logic [DATA_W-1:0]            dump_data,
    output logic                         dump_last,
    output logic                         dump_busy
);

    localparam logic [AW-1:0] ONE_A = AW'(1'b1);

    logic [DATA_W-1:0]          view_s [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] shadow_flat_s;
    logic                       save_en_s;

    // The shadow must stay frozen for the whole stream.
    assign save_en_s = save_req & ~dump_busy;

    for (genvar b = 0; b < NUM_REGS; b++) begin : g_lane
        localparam logic [AW-1:0] LANE = AW'(b);

        logic              hit_s;
        logic [DATA_W-1:0] byte_s;
        logic [DATA_W-1:0] live_r;
        logic [DATA_W-1:0] shadow_r;

        // Per-byte priority: ascending scan so the highest enabled port wins.
        always_comb begin
            hit_s  = 1'b0;
            byte_s = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                logic sel_v;
                sel_v = byte_lane_sel(wr_en[p], wr_pair[p],
                                      wr_addr[p*AW +: AW] == LANE,
                                      (wr_addr[p*AW +: AW] >> 1'b1) == (LANE >> 1'b1));
                hit_s  = hit_s | sel_v;
                byte_s = !sel_v ? byte_s :
                         lane_takes_high(wr_pair[p], LANE[0]) ?
                             wr_data[p*2*DATA_W + DATA_W +: DATA_W] :
                             wr_data[p*2*DATA_W +: DATA_W];
            end
        end

        // Live and shadow byte; save samples the pre-edge live value, so
        // save+restore in one cycle is a clean exchange.
        always_ff @(posedge clk) begin
            if (rst) begin
                live_r   <= '0;
                shadow_r <= '0;
            end else begin
                if (hit_s) begin
                    live_r <= byte_s;
                end else if (restore_req) begin
                    live_r <= shadow_r;
                end
                if (save_en_s) begin
                    shadow_r <= live_r;
                end
            end
        end

`ifdef REGFILE_BYPASS_EN
        assign view_s[b] = hit_s ? byte_s : live_r;
`else
        assign view_s[b] = live_r;
`endif

        assign shadow_flat_s[b*DATA_W +: DATA_W] = shadow_r;
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [AW-1:0]       addr_s;
        logic [2*DATA_W-1:0] word_s;

        assign addr_s = rd_addr[r*AW +: AW];

        // Pair reads return {even, odd}; byte reads are zero-extended.
        always_comb begin
            if (rd_pair[r]) begin
                word_s = {view_s[addr_s & ~ONE_A], view_s[addr_s | ONE_A]};
            end else begin
                word_s = {{DATA_W{1'b0}}, view_s[addr_s]};
            end
        end

        assign rd_data[r*2*DATA_W +: 2*DATA_W] = word_s;
    end

    regfile_dump_ctrl #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_dump_ctrl (
        .clk         (clk),
        .rst         (rst),
        .dump_start  (dump_start),
        .dump_ready  (dump_ready),
        .shadow_flat (shadow_flat_s),
        .dump_valid  (dump_valid),
        .dump_idx    (dump_idx),
        .dump_data   (dump_data),
        .dump_last   (dump_last),
        .dump_busy   (dump_busy)
    );

endmodule

// File: tb/tb_sm83_regfile_mp.sv
// Self-checking bench for sm83_regfile_mp: directed scenarios plus random
// traffic against a behavioural byte-array model of live/shadow banks.
module tb_sm83_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en, wr_pair;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  rd_addr;
    logic [1:0]  rd_pair;
    logic [31:0] rd_data;
    logic        save_req, restore_req, dump_start, dump_valid, dump_ready;
    logic [2:0]  dump_idx;
    logic [7:0]  dump_data;
    logic        dump_last, dump_busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m_live [8];
    logic [7:0] m_sh   [8];
    logic [7:0] m_wd   [8];
    bit         m_hit  [8];
    bit         m_busy;
    int         m_idx;

    sm83_regfile_mp dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_pair(wr_pair), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_pair(rd_pair), .rd_data(rd_data),
        .save_req(save_req), .restore_req(restore_req),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
        .dump_busy(dump_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Same-cycle port writes per byte, later ports overriding earlier ones.
    task automatic compute_writes();
        int a;
        logic [15:0] d;
        for (int b = 0; b < 8; b++) begin m_hit[b] = 1'b0; m_wd[b] = 8'h00; end
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                a = int'(wr_addr[p*3 +: 3]);
                d = wr_data[p*16 +: 16];
                if (wr_pair[p]) begin
                    m_hit[a & 6] = 1'b1; m_wd[a & 6] = d[15:8];
                    m_hit[a | 1] = 1'b1; m_wd[a | 1] = d[7:0];
                end else begin
                    m_hit[a] = 1'b1; m_wd[a] = d[7:0];
                end
            end
        end
    endtask

    function automatic logic [7:0] view(int b);
        return (BYP && m_hit[b]) ? m_wd[b] : m_live[b];
    endfunction

    function automatic logic [15:0] exp_rd(int a, bit pair);
        return pair ? {view(a & 6), view(a | 1)} : {8'h00, view(a)};
    endfunction

    task automatic model_edge();
        logic [7:0] nl [8];
        logic [7:0] ns [8];
        compute_writes();
        if (rst) begin
            for (int b = 0; b < 8; b++) begin m_live[b] = 8'h00; m_sh[b] = 8'h00; end
            m_busy = 1'b0;
            m_idx  = 0;
        end else begin
            for (int b = 0; b < 8; b++) begin
                nl[b] = m_hit[b] ? m_wd[b] : (restore_req ? m_sh[b] : m_live[b]);
                ns[b] = (save_req && !m_busy) ? m_live[b] : m_sh[b];
            end
            for (int b = 0; b < 8; b++) begin m_live[b] = nl[b]; m_sh[b] = ns[b]; end
            if (!m_busy) begin
                if (dump_start) begin m_busy = 1'b1; m_idx = 0; end
            end else if (dump_ready) begin
                if (m_idx == 7) begin m_busy = 1'b0; m_idx = 0; end
                else m_idx = m_idx + 1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 2'b00; wr_pair = 2'b00; wr_addr = 6'd0; wr_data = 32'd0;
        save_req = 1'b0; restore_req = 1'b0; dump_start = 1'b0;
    endtask

    task automatic test_reset();
        idle_in(); dump_ready = 1'b0; rd_addr = 6'd0; rd_pair = 2'b00;
        rst = 1'b1; cycle(); cycle(); rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_addr = {3'(a), 3'(a)}; rd_pair = 2'b10; #1;
            n_total++; if (rd_data[15:0] !== 16'h0000) $display("FAIL reset_byte a=%0d: got %h want 0000", a, rd_data[15:0]); else n_pass++;
            n_total++; if (rd_data[31:16] !== 16'h0000) $display("FAIL reset_pair a=%0d: got %h want 0000", a, rd_data[31:16]); else n_pass++;
        end
        n_total++; if ({dump_valid, dump_busy, dump_last, dump_idx} !== 6'd0) $display("FAIL reset_dump: got v%b b%b l%b i%0d want all 0", dump_valid, dump_busy, dump_last, dump_idx); else n_pass++;
    endtask

    task automatic test_write_conflict();
        wr_en = 2'b11; wr_pair = 2'b00; wr_addr = {3'd2, 3'd2}; wr_data = {16'h0022, 16'h0011};
        cycle(); idle_in();
        rd_addr = {3'd0, 3'd2}; rd_pair = 2'b00; #1;
        n_total++; if (rd_data[15:0] !== 16'h0022) $display("FAIL conflict_byte: got %h want 0022", rd_data[15:0]); else n_pass++;
        wr_en = 2'b11; wr_pair = 2'b01; wr_addr = {3'd5, 3'd4}; wr_data = {16'h0033, 16'hAABB};
        cycle();
        wr_en = 2'b11; wr_pair = 2'b10; wr_addr = {3'd7, 3'd6}; wr_data = {16'hCCDD, 16'h0044};
        cycle(); idle_in();
        rd_addr = {3'd6, 3'd4}; rd_pair = 2'b11; #1;
        n_total++; if (rd_data[15:0] !== 16'hAA33) $display("FAIL conflict_mix_lo: got %h want aa33", rd_data[15:0]); else n_pass++;
        n_total++; if (rd_data[31:16] !== 16'hCCDD) $display("FAIL conflict_mix_hi: got %h want ccdd", rd_data[31:16]); else n_pass++;
    endtask

    task automatic test_pair_rw();
        wr_en = 2'b01; wr_pair = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {16'h0000, 16'hBEEF};
        cycle(); idle_in();
        rd_addr = {3'd2, 3'd3}; rd_pair = 2'b10; #1;
        n_total++; if (rd_data[15:0] !== 16'h00EF) $display("FAIL pair_byte3: got %h want 00ef", rd_data[15:0]); else n_pass++;
        n_total++; if (rd_data[31:16] !== 16'hBEEF) $display("FAIL pair_read2: got %h want beef", rd_data[31:16]); else n_pass++;
        rd_addr = {3'd3, 3'd2}; rd_pair = 2'b10; #1;
        n_total++; if (rd_data[15:0] !== 16'h00BE) $display("FAIL pair_byte2: got %h want 00be", rd_data[15:0]); else n_pass++;
        n_total++; if (rd_data[31:16] !== 16'hBEEF) $display("FAIL pair_read3: got %h want beef", rd_data[31:16]); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [15:0] want;
        want = BYP ? 16'h005A : {8'h00, m_live[1]};
        wr_en = 2'b01; wr_pair = 2'b00; wr_addr = {3'd0, 3'd1}; wr_data = {16'h0000, 16'h005A};
        rd_addr = {3'd0, 3'd1}; rd_pair = 2'b00; #1;
        n_total++; if (rd_data[15:0] !== want) $display("FAIL bypass_same: got %h want %h", rd_data[15:0], want); else n_pass++;
        cycle(); idle_in(); #1;
        n_total++; if (rd_data[15:0] !== 16'h005A) $display("FAIL bypass_next: got %h want 005a", rd_data[15:0]); else n_pass++;
        wr_en = 2'b11; wr_pair = 2'b01; wr_addr = {3'd0, 3'd0}; wr_data = {16'h0077, 16'h1234};
        rd_addr = {3'd0, 3'd1}; rd_pair = 2'b11; #1;
        compute_writes(); want = exp_rd(0, 1'b1);
        n_total++; if (rd_data[15:0] !== want) $display("FAIL bypass_prio: got %h want %h", rd_data[15:0], want); else n_pass++;
        cycle(); idle_in();
    endtask

    task automatic test_random();
        logic [15:0] want;
        for (int i = 0; i < 300; i++) begin
            wr_en = 2'($urandom); wr_pair = 2'($urandom);
            wr_addr = 6'($urandom); wr_data = 32'($urandom);
            save_req = ($urandom_range(7) == 0); restore_req = ($urandom_range(7) == 0);
            rd_addr = 6'($urandom); rd_pair = 2'($urandom); #1;
            compute_writes();
            for (int r = 0; r < 2; r++) begin
                want = exp_rd(int'(rd_addr[r*3 +: 3]), rd_pair[r]);
                n_total++; if (rd_data[r*16 +: 16] !== want) $display("FAIL rand_rd%0d it=%0d: got %h want %h", r, i, rd_data[r*16 +: 16], want); else n_pass++;
            end
            cycle();
        end
        idle_in();
    endtask

    task automatic test_exchange();
        int k, nv;
        idle_in(); dump_ready = 1'b1;
        wr_en = 2'b11; wr_pair = 2'b11; wr_addr = {3'd2, 3'd0}; wr_data = {16'h1213, 16'h1011}; cycle();
        wr_addr = {3'd6, 3'd4}; wr_data = {16'h1617, 16'h1415}; cycle();
        idle_in(); save_req = 1'b1; cycle();
        idle_in(); wr_en = 2'b11; wr_pair = 2'b11; wr_addr = {3'd2, 3'd0}; wr_data = 32'hFFFF_FFFF; cycle();
        wr_addr = {3'd6, 3'd4}; cycle();
        idle_in(); save_req = 1'b1; restore_req = 1'b1; cycle();
        idle_in();
        for (int a = 0; a < 8; a++) begin
            rd_addr = {3'd0, 3'(a)}; rd_pair = 2'b00; #1;
            n_total++; if (rd_data[15:0] !== 16'(8'h10 + a)) $display("FAIL exx_live a=%0d: got %h want %h", a, rd_data[15:0], 16'(8'h10 + a)); else n_pass++;
        end
        dump_start = 1'b1; cycle(); dump_start = 1'b0;
        k = 0; nv = 0;
        for (int c = 0; c < 20; c++) begin
            if (dump_valid) begin
                nv++;
                n_total++; if (dump_data !== 8'hFF || dump_idx !== 3'(k)) $display("FAIL exx_shadow: got idx %0d data %h want idx %0d data ff", dump_idx, dump_data, k); else n_pass++;
                k++;
            end
            cycle();
        end
        n_total++; if (nv !== 8) $display("FAIL exx_beats: got %0d want 8", nv); else n_pass++;
    endtask

    task automatic test_dump_stall();
        int beats, acc;
        bit exp_last;
        idle_in(); dump_ready = 1'b0;
        wr_en = 2'b11; wr_pair = 2'b11; wr_addr = {3'd2, 3'd0}; wr_data = 32'($urandom); cycle();
        wr_addr = {3'd6, 3'd4}; wr_data = 32'($urandom); cycle();
        idle_in(); save_req = 1'b1; cycle();
        idle_in(); dump_start = 1'b1; cycle(); dump_start = 1'b0;
        beats = 0;
        for (int c = 0; c < 60 && beats < 8; c++) begin
            idle_in();
            dump_ready = (c % 2 == 0);
            if (c == 3) dump_start = 1'b1;
            if (c == 5) begin
                save_req = 1'b1; wr_en = 2'b01; wr_pair = 2'b01; wr_addr = 6'd0; wr_data = 32'h0000_5AA5;
            end
            if (c == 7) restore_req = 1'b1;
            #1;
            exp_last = m_busy && (m_idx == 7);
            n_total++; if (dump_valid !== m_busy || dump_idx !== 3'(m_idx) || dump_last !== exp_last) $display("FAIL stall_ctl c=%0d: got v%b i%0d l%b want v%b i%0d l%b", c, dump_valid, dump_idx, dump_last, m_busy, m_idx, exp_last); else n_pass++;
            n_total++; if (dump_data !== m_sh[m_idx]) $display("FAIL stall_data c=%0d: got %h want %h", c, dump_data, m_sh[m_idx]); else n_pass++;
            if (dump_valid && dump_ready) beats++;
            cycle();
        end
        idle_in(); dump_ready = 1'b0; #1;
        n_total++; if (beats !== 8) $display("FAIL stall_beats: got %0d want 8", beats); else n_pass++;
        n_total++; if (dump_busy !== 1'b0) $display("FAIL stall_done: got busy %b want 0", dump_busy); else n_pass++;
        dump_start = 1'b1; cycle(); dump_start = 1'b0; dump_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m_busy) begin
                n_total++; if (dump_data !== m_sh[m_idx] || dump_idx !== 3'(m_idx)) $display("FAIL frozen_shadow: got i%0d %h want i%0d %h", dump_idx, dump_data, m_idx, m_sh[m_idx]); else n_pass++;
                acc++;
            end
            cycle();
        end
        n_total++; if (acc !== 8) $display("FAIL full_dump_len: got %0d want 8", acc); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        idle_in(); dump_ready = 1'b1;
        dump_start = 1'b1; cycle(); dump_start = 1'b0;
        for (int c = 0; c < 10 && m_idx < 2; c++) cycle();
        rst = 1'b1; save_req = 1'b1; restore_req = 1'b1;
        wr_en = 2'b11; wr_pair = 2'b11; wr_addr = {3'd2, 3'd0}; wr_data = 32'hDEAD_BEEF;
        cycle(); rst = 1'b0; idle_in(); dump_ready = 1'b0; #1;
        n_total++; if (dump_valid !== 1'b0 || dump_busy !== 1'b0) $display("FAIL midrst_dump: got v%b b%b want 0 0", dump_valid, dump_busy); else n_pass++;
        for (int a = 0; a < 8; a += 2) begin
            rd_addr = {3'(a), 3'(a + 1)}; rd_pair = 2'b11; #1;
            n_total++; if (rd_data !== 32'h0) $display("FAIL midrst_read a=%0d: got %h want 0", a, rd_data); else n_pass++;
        end
        dump_start = 1'b1; cycle(); dump_start = 1'b0;
        n_total++; if (dump_valid !== 1'b1 || dump_idx !== 3'd0 || dump_data !== 8'h00) $display("FAIL midrst_restart: got v%b i%0d d%h want v1 i0 d00", dump_valid, dump_idx, dump_data); else n_pass++;
        dump_ready = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        dump_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_conflict();
        test_pair_rw();
        test_bypass();
        test_random();
        test_exchange();
        test_dump_stall();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sm83_regfile_mp.md
# sm83_regfile_mp

Parametrised multi-port register file for the sm83 core: a generic byte-addressed bank with NUM_RD read ports and NUM_WR write ports. Adjacent registers can be read or written as a 16-bit pair.
- A shadow bank supports single-cycle save, restore and exchange.
- A valid/ready dump engine streams the shadow bank to the debug port.
- Successor to the fixed-map register file; holds the gp/pair registers for wider or multi-issue datapaths.

## Interface
Parameters:
- DATA_W, 8, bits per register
- NUM_REGS, 8, register count; even, ≥2
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports; higher index = higher priority
- AW, $clog2(NUM_REGS), address width (derived, not overridable)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  NUM_WR  per-port write enable
- wr_pair  in  NUM_WR  1 = 16-bit pair write, 0 = byte write
- wr_addr  in  NUM_WR×AW  register address; bit 0 ignored for pair writes
- wr_data  in  NUM_WR×2·DATA_W  byte writes use low DATA_W bits
- rd_addr  in  NUM_RD×AW  read address; bit 0 ignored for pair reads
- rd_pair  in  NUM_RD  1 = pair read
- rd_data  out  NUM_RD×2·DATA_W  pair {reg[a&~1], reg[a|1]}; byte reads zero-extended
- save_req  in  1  copy live bank into shadow
- restore_req  in  1  copy shadow into live bank
- dump_start  in  1  begin streaming shadow bank
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  sink accepts beat
- dump_idx  out  AW  index of current beat
- dump_data  out  DATA_W  shadow[dump_idx]
- dump_last  out  1  beat is index NUM_REGS-1
- dump_busy  out  1  dump engine not IDLE

## Operation
- Pair layout: even address is the high byte, odd address is the low byte.
- A pair write updates both bytes. A byte write updates one.
- Write conflicts are resolved per byte: the highest-indexed enabled port targeting that byte wins.
- Reads are combinational from the live bank, subject to REGFILE_BYPASS_EN.
- save_req: shadow ← live bank as held before this edge. This cycle's writes are not captured.
- restore_req: live ← shadow for every byte not written by a port this cycle. Port writes win.
- save_req and restore_req together: atomic exchange of live and shadow (EXX-style).
- save_req is ignored while dump_busy, so the shadow stays frozen during a stream. restore_req is allowed while dump_busy.
- Dump FSM states:
  - IDLE: dump_start → STREAM with idx = 0.
  - STREAM: dump_valid = 1. On valid&ready with idx < NUM_REGS-1, idx increments. On valid&ready with dump_last, → IDLE.
- dump_start is ignored outside IDLE.
- Stalls: dump_idx and dump_data hold while dump_ready = 0.

## Timing
- Write latency: 1 cycle. Data is visible on reads the cycle after the edge, or the same cycle with bypass.
- Read latency: 0, combinational.
- Save, restore and exchange complete in 1 cycle.
- dump_valid asserts the cycle after dump_start is sampled.
- A full dump with ready held high takes NUM_REGS cycles of dump_valid.
- Reset values: all live and shadow registers 0; FSM IDLE; dump_idx 0; dump_valid, dump_last and dump_busy 0; rd_data reflects zeros.
- Reset mid-stream: next cycle IDLE with dump_valid 0. The partial transfer is abandoned.
- Reset dominates all same-cycle writes, saves and restores.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Each read port forwards the winning same-cycle port write per byte, so read-after-write is seen in the same cycle.
  - Restore data is not forwarded.
- REGFILE_BYPASS_EN undefined: reads return pre-edge state only. This gives a shorter combinational path.

## Structure
- sm83_pkg gains:
  - dump_state_t enum {DUMP_IDLE, DUMP_STREAM}
  - localparam DUMP_W
  - a byte-lane write-select helper function
- Sub-module regfile_dump_ctrl owns the FSM, index counter and valid/ready handshake. It indexes the shadow bank.
- Priority and byte-lane resolution are generate loops in the top level.

## Test plan
- Ports 0 and 1 byte-write addr 2 with 0x11 and 0x22 in the same cycle → reg[2] = 0x22 next cycle.
- Pair write addr 3 data 0xBEEF → reg[2] = 0xBE, reg[3] = 0xEF. Byte read addr 3 → 0x00EF. Pair read addr 2 → 0xBEEF.
- Load regs with 0x10+i, save_req, overwrite all with 0xFF, save_req+restore_req together → live = 0x10+i, shadow = 0xFF.
- dump_start with dump_ready toggling 1,0,1… → exactly NUM_REGS accepted beats carrying idx 0..7 in order, dump_last only on idx 7, data stable across stalls.
- rst asserted on the 3rd beat → dump_valid = 0 next cycle; all reads 0; a new dump_start restarts at idx 0.
- With bypass, write 0x5A to addr 1 and read addr 1 in the same cycle → rd_data = 0x005A that cycle. Without bypass → old value that cycle, 0x5A next cycle.
